adder_tree_pipelined: RTL

- Parametrised N-input adder, the generalisation of the 3-input adder: a balanced binary tree with a register stage after every tree level.
- Valid/ready streaming handshake with full backpressure.
- Selectable signed/unsigned operands and full-precision or wrapping output.
- Sits in the arithmetic datapath examples and is timed and used standalone; no external I/O wrapper is needed because the block is already registered.

---
 rtl/adder_tree_pkg.sv | 32 +++
 rtl/adder_tree_level.sv | 71 +++++++
 rtl/adder_tree_pipelined.sv | 66 ++++++
 3 files changed

// File: rtl/adder_tree_pkg.sv
// Shared sizing helpers for the pipelined adder tree: level count, node count per level
// and the operand width carried at each level.
package adder_tree_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Each level halves the node count, rounding up so an odd node passes through.
  function automatic int level_nodes(input int n, input int k);
    int m;
    m = n;
    for (int i = 0; i < 32; i++) begin
      if (i < k) m = (m + 1) / 2;
    end
    return m;
  endfunction

  function automatic int level_width(input int width, input int k, input int full_precision);
    return (full_precision != 0) ? width + k : width;
  endfunction

  function automatic int out_width(input int width, input int num_inputs, input int full_precision);
    return (full_precision != 0) ? width + clog2(num_inputs) : width;
  endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered level of the adder tree: pairs of nodes are extended and summed, an odd
// trailing node is passed through, and the results plus a valid bit load when enabled.
module adder_tree_level
  import adder_tree_pkg::*;
#(
  parameter int IN_NODES    = 3,
  parameter int IN_WIDTH    = 16,
  parameter int OUT_WIDTH_L = 17,
  parameter int SIGNED      = 0
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        i_en,
  input  logic                                        i_valid,
  input  logic [IN_NODES*IN_WIDTH-1:0]                i_data,
  output logic                                        o_valid,
  output logic [((IN_NODES+1)/2)*OUT_WIDTH_L-1:0]     o_data
);

  localparam int OUT_NODES = (IN_NODES + 1) / 2;
  localparam int EXT       = OUT_WIDTH_L - IN_WIDTH;

  logic [OUT_NODES*OUT_WIDTH_L-1:0] w_sum;
  logic [OUT_NODES*OUT_WIDTH_L-1:0] r_data;
  logic                             r_valid;

  for (genvar j = 0; j < OUT_NODES; j++) begin : g_node
    logic [IN_WIDTH-1:0]    w_a;
    logic [OUT_WIDTH_L-1:0] w_a_ext;

    assign w_a = i_data[2*j*IN_WIDTH +: IN_WIDTH];

    // In wrapping mode the level width does not grow, so no extension is needed.
    if (EXT > 0) begin : g_ext_a
      assign w_a_ext = {{EXT{(SIGNED != 0) && w_a[IN_WIDTH-1]}}, w_a};
    end else begin : g_ext_a
      assign w_a_ext = w_a[OUT_WIDTH_L-1:0];
    end

    if (2*j + 1 < IN_NODES) begin : g_add
      logic [IN_WIDTH-1:0]    w_b;
      logic [OUT_WIDTH_L-1:0] w_b_ext;

      assign w_b = i_data[(2*j+1)*IN_WIDTH +: IN_WIDTH];

      if (EXT > 0) begin : g_ext_b
        assign w_b_ext = {{EXT{(SIGNED != 0) && w_b[IN_WIDTH-1]}}, w_b};
      end else begin : g_ext_b
        assign w_b_ext = w_b[OUT_WIDTH_L-1:0];
      end

      assign w_sum[j*OUT_WIDTH_L +: OUT_WIDTH_L] = w_a_ext + w_b_ext;
    end else begin : g_pass
      assign w_sum[j*OUT_WIDTH_L +: OUT_WIDTH_L] = w_a_ext;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_en) begin
      r_valid <= i_valid;
      r_data  <= w_sum;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/adder_tree_pipelined.sv
// N-input balanced adder tree with a register bank after every level and a single global
// stall: the whole pipeline advances whenever the output is consumed or empty.
module adder_tree_pipelined
  import adder_tree_pkg::*;
#(
  parameter int NUM_INPUTS     = 3,
  parameter int WIDTH          = 16,
  parameter int SIGNED         = 0,
  parameter int FULL_PRECISION = 1
) (
  input  logic                                                   clk,
  input  logic                                                   rst,
  input  logic                                                   in_valid,
  output logic                                                   in_ready,
  input  logic [NUM_INPUTS*WIDTH-1:0]                            in,
  output logic                                                   out_valid,
  input  logic                                                   out_ready,
  output logic [out_width(WIDTH, NUM_INPUTS, FULL_PRECISION)-1:0] out
);

  localparam int LEVELS = clog2(NUM_INPUTS);

  logic w_en;

  assign w_en     = out_ready || !out_valid;
  assign in_ready = w_en;

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int IN_N  = level_nodes(NUM_INPUTS, k - 1);
    localparam int OUT_N = level_nodes(NUM_INPUTS, k);
    localparam int IN_W  = level_width(WIDTH, k - 1, FULL_PRECISION);
    localparam int OUT_W = level_width(WIDTH, k, FULL_PRECISION);

    logic [IN_N*IN_W-1:0]   w_data_in;
    logic                   w_valid_in;
    logic [OUT_N*OUT_W-1:0] w_data;
    logic                   w_valid;

    if (k == 1) begin : g_src
      assign w_data_in  = in;
      assign w_valid_in = in_valid;
    end else begin : g_src
      assign w_data_in  = g_lvl[k-1].w_data;
      assign w_valid_in = g_lvl[k-1].w_valid;
    end

    adder_tree_level #(
      .IN_NODES    (IN_N),
      .IN_WIDTH    (IN_W),
      .OUT_WIDTH_L (OUT_W),
      .SIGNED      (SIGNED)
    ) u_level (
      .clk     (clk),
      .rst     (rst),
      .i_en    (w_en),
      .i_valid (w_valid_in),
      .i_data  (w_data_in),
      .o_valid (w_valid),
      .o_data  (w_data)
    );
  end

  assign out       = g_lvl[LEVELS].w_data;
  assign out_valid = g_lvl[LEVELS].w_valid;

endmodule
